// File: rtl/cla_2.sv
// 16-bit two-level carry-lookahead adder with a single registered output stage.
// Optional signed-overflow output ovf is enabled by defining CLA_OVF_EN.

module cla_2_grp #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] p,
  input  logic [GROUP-1:0] g,
  input  logic             ci,
  output logic [GROUP-1:0] c,
  output logic [GROUP-1:0] s,
  output logic             gp,
  output logic             gg
);
  // Every in-group carry is a flat sum of products from ci.
  always_comb begin
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    s    = p ^ c;
    gp   = &p;
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  end
endmodule

module cla_2 #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
`ifdef CLA_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int NGRP = WIDTH / GROUP;

  logic [NGRP-1:0][GROUP-1:0] p, g, c, s;
  logic [NGRP-1:0]            gp, gg;
  logic [NGRP:0]              gc;

  assign p = a ^ b;
  assign g = a & b;

  for (genvar k = 0; k < NGRP; k++) begin : g_grp
    cla_2_grp #(.GROUP(GROUP)) u_grp (
      .p  (p[k]),
      .g  (g[k]),
      .ci (gc[k]),
      .c  (c[k]),
      .s  (s[k]),
      .gp (gp[k]),
      .gg (gg[k])
    );
  end

  // Second-level lookahead: each group carry-in straight from cin and group P/G.
  always_comb begin
    gc[0] = cin;
    gc[1] = gg[0] | (gp[0] & cin);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & cin);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= s;
        cout <= gc[NGRP];
      end
    end
  end

`ifdef CLA_OVF_EN
  // Overflow compares the carries into and out of the sign bit.
  always_ff @(posedge clk) begin
    if (rst)           ovf <= 1'b0;
    else if (in_valid) ovf <= gc[NGRP] ^ c[NGRP-1][GROUP-1];
  end
`endif
endmodule

// File: tb/tb_cla_2.sv
// Self-checking bench for cla_2: directed boundary cases plus random operands
// against an arithmetic reference model.

module tb_cla_2;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] a, b;
  logic        cin;
  logic [15:0] sum;
  logic        cout;
  logic        out_valid;
`ifdef CLA_OVF_EN
  logic        ovf;
  logic        m_ovf;
`endif

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] m_sum;
  logic        m_cout;
  logic        m_vld;

  always #5 clk = ~clk;

  cla_2 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
    .out_valid (out_valid)
`ifdef CLA_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, update the model, compare after the edge.
  task automatic step(input string tag, input logic r, input logic v,
                      input logic [15:0] ta, input logic [15:0] tb, input logic tc);
    int full;
    rst = r; in_valid = v; a = ta; b = tb; cin = tc;
    @(posedge clk);
    #1;
    full = int'(ta) + int'(tb) + int'(tc);
    if (r) begin
      m_sum = '0; m_cout = 1'b0; m_vld = 1'b0;
`ifdef CLA_OVF_EN
      m_ovf = 1'b0;
`endif
    end else begin
      m_vld = v;
      if (v) begin
        m_sum  = full[15:0];
        m_cout = full[16];
`ifdef CLA_OVF_EN
        m_ovf  = (ta[15] == tb[15]) && (full[15] != ta[15]);
`endif
      end
    end
    chk({tag, ".sum"},  {16'h0, sum},        {16'h0, m_sum});
    chk({tag, ".cout"}, {31'h0, cout},       {31'h0, m_cout});
    chk({tag, ".vld"},  {31'h0, out_valid},  {31'h0, m_vld});
`ifdef CLA_OVF_EN
    chk({tag, ".ovf"},  {31'h0, ovf},        {31'h0, m_ovf});
`endif
  endtask

  initial begin
    m_sum = '0; m_cout = 1'b0; m_vld = 1'b0;
`ifdef CLA_OVF_EN
    m_ovf = 1'b0;
`endif
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    @(negedge clk);

    step("rst0", 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    step("rst1", 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    step("idle", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    chk("idle.sum0", {16'h0, sum}, 32'h0);

    step("cin1",   1'b0, 1'b1, 16'd0,   16'd0, 1'b1);
    chk("cin1.lit", {16'h0, sum}, 32'd1);
    step("g0to1",  1'b0, 1'b1, 16'd14,  16'd1, 1'b1);
    chk("g0to1.lit", {16'h0, sum}, 32'd16);
    step("five",   1'b0, 1'b1, 16'd5,   16'd0, 1'b0);
    step("k1000",  1'b0, 1'b1, 16'd999, 16'd0, 1'b1);
    chk("k1000.lit", {16'h0, sum}, 32'd1000);
    step("allff",  1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    chk("allff.lit", {15'h0, cout, sum}, 32'h1FFFF);
    step("chain",  1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b1);
    chk("chain.lit", {15'h0, cout, sum}, 32'h10000);
    step("sgnovf", 1'b0, 1'b1, 16'h8000, 16'h8000, 1'b0);
`ifdef CLA_OVF_EN
    chk("sgnovf.lit", {31'h0, ovf}, 32'h1);
`endif
    step("pos_ovf", 1'b0, 1'b1, 16'h7FFF, 16'h0001, 1'b0);

    for (int i = 0; i < 3; i++)
      step("hold", 1'b0, 1'b0, 16'(i * 77 + 3), 16'hABCD, 1'b1);
    chk("hold.lit", {16'h0, sum}, 32'h8000);

    step("rstvld", 1'b1, 1'b1, 16'd100, 16'd200, 1'b0);
    chk("rstvld.lit", {16'h0, sum}, 32'h0);

    for (int i = 0; i < 10000; i++)
      step("rnd", 1'b0, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom));

    // Mixed valid/idle traffic to exercise the hold path with random data.
    for (int i = 0; i < 300; i++)
      step("mix", 1'b0, 1'($urandom_range(0, 3) != 0),
           16'($urandom), 16'($urandom), 1'($urandom));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/cla_2.md
Name: cla_2

Overview:
- 16-bit two-level carry-lookahead adder: sum = a + b + cin, with carry-out.
- Four 4-bit CLA groups produce group propagate/generate; a second-level lookahead unit computes the inter-group carries. No ripple path between groups.
- Operands are captured combinationally; results are registered once on the clock, so the block drops into a synchronous datapath stage.

Parameters:
- WIDTH, 16, operand width. Fixed at 16; any other value is unsupported.
- GROUP, 4, bits per first-level lookahead group. Fixed at 4; WIDTH/GROUP = 4 groups.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  qualifies a, b, cin this cycle
- a  input  16  unsigned operand A
- b  input  16  unsigned operand B
- cin  input  1  carry-in
- sum  output  16  registered a+b+cin, bits [15:0]
- cout  output  1  registered carry-out of bit 15
- out_valid  output  1  sum/cout hold a result captured from an in_valid cycle

Behaviour:
- Bit level: p[i] = a[i]^b[i], g[i] = a[i]&b[i].
- Group k (bits 4k..4k+3):
  - P_k = AND of its p bits.
  - G_k = g3 | p3g2 | p3p2g1 | p3p2p1g0 (indices local to the group).
- Second level: c4 = G0|P0·cin; c8 = G1|P1·G0|P1·P0·cin; c12 and c16 extend the same pattern. c16 is cout.
- In-group carries use full lookahead from the group carry-in, never ripple.
- sum[i] = p[i] ^ c[i]. Arithmetic is modulo 2^16; the 17th bit appears only on cout.
- Latency: exactly 1 clock. Operands present at rising edge N appear on sum/cout after edge N. No back-pressure; a new operand set is accepted every cycle.
- On each rising edge with rst=0:
  - If in_valid=1: sum/cout load the new result and out_valid<=1.
  - If in_valid=0: sum/cout hold their previous values and out_valid<=0.
- On a rising edge with rst=1: sum<=0, cout<=0, out_valid<=0, regardless of in_valid. A reset asserted while a result is pending discards it.
- Reset values: sum=16'h0000, cout=0, out_valid=0.
- Boundary conditions:
  - a=b=16'hFFFF, cin=1 gives sum=16'hFFFF, cout=1.
  - a=16'hFFFF, b=0, cin=1 gives sum=0, cout=1 (full propagate chain).
  - X-free when inputs are known.
- The combinational path from inputs to the register D pins contains no latches.

Optional Feature:
- Macro CLA_OVF_EN.
- When defined: adds output port ovf (1 bit, registered alongside sum), the signed two's-complement overflow ovf = c16 ^ c15. It resets to 0 and holds when in_valid=0.
- When undefined: the ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
- rst=1 for 2 cycles, then rst=0 with in_valid=0 -> sum=0, cout=0, out_valid=0.
- in_valid=1; a=0,b=0,cin=1 -> next cycle sum=1, cout=0, out_valid=1. Then a=14,b=1,cin=1 -> sum=16, cout=0.
- a=5,b=0,cin=0 -> sum=5, cout=0. Then a=999,b=0,cin=1 -> sum=1000, cout=0.
- a=16'hFFFF,b=0,cin=1 -> sum=0, cout=1. a=16'h8000,b=16'h8000,cin=0 -> sum=0, cout=1, and ovf=1 when CLA_OVF_EN is defined.
- Drop in_valid to 0 for 3 cycles -> sum/cout hold the last result, out_valid=0. Assert rst alongside in_valid=1 and a=100,b=200 -> outputs 0 next cycle, not 300.
- 10k random a/b/cin with in_valid=1 -> every registered result equals the 17-bit reference a+b+cin, one cycle later.
